// File: rtl/serial_packet_buffer.sv
// rtl/serial_packet_buffer.sv - serial packet receiver holding one packet for indexed reads
// Optional idle-line abort in RECV is enabled by defining SERIAL_PACKET_TIMEOUT_EN.
module serial_packet_buffer #(
  parameter int WIDTH          = 16,
  parameter int LOGSIZE        = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               serialClock,
  input  logic               serialData,
  input  logic [LOGSIZE-1:0] rdIndex,
  output logic [WIDTH-1:0]   rdData,
  output logic               packetValid,
  input  logic               packetAck,
  output logic               receiving,
  output logic [7:0]         dropCount
);

  localparam int WORDS = 1 << LOGSIZE;
  localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [LOGSIZE-1:0] LAST_IDX = '1;
  localparam logic [CW-1:0]      BIT_TOP  = CW'(WIDTH - 1);

  typedef enum logic {SEEK, RECV} state_t;

  state_t               state;
  logic [5:0]           hist;
  logic                 bit_strobe;
  logic                 bit_value;
  logic [6:0]           seek;
  logic [WIDTH-2:0]     shift;
  logic [CW-1:0]        bit_cnt;
  logic [LOGSIZE-1:0]   widx;
  logic [WIDTH-1:0]     fill [WORDS];
  logic [WIDTH-1:0]     held [WORDS];

  logic [7:0]           seek_next;
  logic [WIDTH-1:0]     new_word;
  logic [7:0]           drop_inc;

  assign seek_next = {seek, bit_value};
  assign new_word  = {shift, bit_value};
  assign drop_inc  = (dropCount == 8'hFF) ? 8'hFF : dropCount + 8'd1;
  assign rdData    = held[rdIndex];

`ifdef SERIAL_PACKET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] idle_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  // A bit is a high pulse of at least 6 samples; data is taken one cycle after the 6th.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hist       <= '0;
      bit_strobe <= 1'b0;
      bit_value  <= 1'b0;
    end else if (hist == 6'h3F) begin
      bit_strobe <= 1'b1;
      bit_value  <= serialData;
      hist       <= '0;
    end else begin
      bit_strobe <= 1'b0;
      hist       <= {hist[4:0], serialClock};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SEEK;
      seek        <= '0;
      shift       <= '0;
      bit_cnt     <= '0;
      widx        <= '0;
      packetValid <= 1'b0;
      receiving   <= 1'b0;
      dropCount   <= '0;
      for (int i = 0; i < WORDS; i++) begin
        fill[i] <= '0;
        held[i] <= '0;
      end
`ifdef SERIAL_PACKET_TIMEOUT_EN
      idle_cnt    <= '0;
`endif
    end else begin
      if (packetAck && packetValid) packetValid <= 1'b0;

      case (state)
        SEEK: begin
`ifdef SERIAL_PACKET_TIMEOUT_EN
          idle_cnt <= '0;
`endif
          if (bit_strobe) begin
            if (seek_next == 8'hAB) begin
              state     <= RECV;
              receiving <= 1'b1;
              seek      <= '0;
              bit_cnt   <= BIT_TOP;
              widx      <= '0;
            end else begin
              seek <= seek_next[6:0];
            end
          end
        end

        RECV: begin
`ifdef SERIAL_PACKET_TIMEOUT_EN
          idle_cnt <= serialClock ? '0 : idle_cnt + 1'b1;
`endif
          if (bit_strobe) begin
            shift <= new_word[WIDTH-2:0];
            if (bit_cnt == '0) begin
              fill[widx] <= new_word;
              bit_cnt    <= BIT_TOP;
              if (widx == LAST_IDX) begin
                state     <= SEEK;
                receiving <= 1'b0;
                seek      <= '0;
                widx      <= '0;
                // The final word is still in flight, so the swap takes it from new_word.
                if (!packetValid || packetAck) begin
                  packetValid <= 1'b1;
                  for (int i = 0; i < WORDS; i++)
                    held[i] <= (widx == LOGSIZE'(i)) ? new_word : fill[i];
                end else begin
                  dropCount <= drop_inc;
                end
              end else begin
                widx <= widx + 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
`ifdef SERIAL_PACKET_TIMEOUT_EN
          else if (!serialClock && idle_cnt == IDLE_LAST) begin
            state     <= SEEK;
            receiving <= 1'b0;
            seek      <= '0;
            widx      <= '0;
            idle_cnt  <= '0;
            dropCount <= drop_inc;
          end
`endif
        end

        default: state <= SEEK;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_packet_buffer.sv
// tb/tb_serial_packet_buffer.sv - scoreboard bench for serial_packet_buffer
`timescale 1ns/1ps
module tb_serial_packet_buffer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        serialClock = 1'b0;
  logic        serialData = 1'b0;
  logic [0:0]  rdIndex;
  logic [15:0] rdData;
  logic        packetValid;
  logic        packetAck = 1'b0;
  logic        receiving;
  logic [7:0]  dropCount;

  logic        rd_mon = 1'b0;
  logic        rd_stim = 1'b0;
  logic        mon_busy = 1'b0;
  assign rdIndex = mon_busy ? rd_mon : rd_stim;

  int total = 0;
  int passed = 0;

  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
  } exp_t;
  exp_t exp_q[$];

  logic gap_seen;

  serial_packet_buffer dut (
    .clock(clock),
    .reset_n(reset_n),
    .serialClock(serialClock),
    .serialData(serialData),
    .rdIndex(rdIndex),
    .rdData(rdData),
    .packetValid(packetValid),
    .packetAck(packetAck),
    .receiving(receiving),
    .dropCount(dropCount)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
  endtask

  // One bit: 8 cycles high, 8 low; optional ack lands on the completion edge.
  task automatic send_bit(input logic b, input logic ack_done);
    @(negedge clock);
    serialData  = b;
    serialClock = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (ack_done && k == 7) packetAck = 1'b1;
      if (ack_done && k == 8) packetAck = 1'b0;
      if (ack_done && !packetValid) gap_seen = 1'b1;
    end
    serialClock = 1'b0;
    repeat (7) @(negedge clock);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n, input logic ack_last);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], ack_last && i == 0);
  endtask

  task automatic send_packet(input logic [15:0] w0, input logic [15:0] w1, input logic ack_last);
    send_bits(16'h00AB, 8, 1'b0);
    send_bits(w0, 16, 1'b0);
    send_bits(w1, 16, ack_last);
  endtask

  task automatic do_ack();
    @(negedge clock);
    packetAck = 1'b1;
    @(negedge clock);
    packetAck = 1'b0;
    check("ack_clears_valid", {31'd0, packetValid}, 32'd0);
  endtask

  task automatic read_word(input logic idx, output logic [15:0] w);
    rd_stim = idx;
    #1;
    w = rdData;
  endtask

  // Monitor: each new held packet is compared against the oldest expectation.
  initial begin
    logic pv_prev;
    exp_t e;
    pv_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (packetValid && !pv_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_packet", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          mon_busy = 1'b1;
          rd_mon = 1'b0;
          #1 check("mon_word0", {16'd0, rdData}, {16'd0, e.w0});
          rd_mon = 1'b1;
          #1 check("mon_word1", {16'd0, rdData}, {16'd0, e.w1});
          mon_busy = 1'b0;
        end
      end
      pv_prev = packetValid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    repeat (3) @(negedge clock);
    check("rst_valid", {31'd0, packetValid}, 32'd0);
    check("rst_receiving", {31'd0, receiving}, 32'd0);
    check("rst_drop", {24'd0, dropCount}, 32'd0);
    check("rst_rddata", {16'd0, rdData}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    exp_q.push_back('{16'h1234, 16'hABCD});
    send_packet(16'h1234, 16'hABCD, 1'b0);
    check("p1_drop", {24'd0, dropCount}, 32'd0);
    check("p1_receiving", {31'd0, receiving}, 32'd0);
    check("p1_valid", {31'd0, packetValid}, 32'd1);
    do_ack();

    send_bits(16'h0006, 3, 1'b0);
    @(negedge clock);
    serialClock = 1'b1;
    repeat (5) @(negedge clock);
    serialClock = 1'b0;
    repeat (8) @(negedge clock);
    exp_q.push_back('{16'h1234, 16'hABCD});
    send_packet(16'h1234, 16'hABCD, 1'b0);
    check("noise_drop", {24'd0, dropCount}, 32'd0);

    send_packet(16'h5555, 16'h6666, 1'b0);
    check("drop_count1", {24'd0, dropCount}, 32'd1);
    check("drop_valid", {31'd0, packetValid}, 32'd1);
    read_word(1'b0, w);
    check("drop_keep_w0", {16'd0, w}, 32'h1234);
    read_word(1'b1, w);
    check("drop_keep_w1", {16'd0, w}, 32'hABCD);
    do_ack();
    read_word(1'b0, w);
    check("after_ack_w0", {16'd0, w}, 32'h1234);
    exp_q.push_back('{16'h0F0F, 16'hF0F0});
    send_packet(16'h0F0F, 16'hF0F0, 1'b0);
    check("p3_drop", {24'd0, dropCount}, 32'd1);

    gap_seen = 1'b0;
    send_packet(16'h1111, 16'h2222, 1'b1);
    check("sim_ack_no_gap", {31'd0, gap_seen}, 32'd0);
    check("sim_ack_valid", {31'd0, packetValid}, 32'd1);
    check("sim_ack_drop", {24'd0, dropCount}, 32'd1);
    read_word(1'b0, w);
    check("sim_ack_w0", {16'd0, w}, 32'h1111);
    read_word(1'b1, w);
    check("sim_ack_w1", {16'd0, w}, 32'h2222);

    send_bits(16'h00AB, 8, 1'b0);
    send_bits(16'h03FF, 10, 1'b0);
    check("mid_receiving", {31'd0, receiving}, 32'd1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("mid_rst_receiving", {31'd0, receiving}, 32'd0);
    check("mid_rst_valid", {31'd0, packetValid}, 32'd0);
    check("mid_rst_drop", {24'd0, dropCount}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    exp_q.push_back('{16'hCAFE, 16'hBEEF});
    send_packet(16'hCAFE, 16'hBEEF, 1'b0);
    check("post_rst_drop", {24'd0, dropCount}, 32'd0);
    do_ack();

    send_bits(16'h00AB, 8, 1'b0);
    send_bits(16'h0155, 10, 1'b0);
    repeat (100) @(negedge clock);
`ifdef SERIAL_PACKET_TIMEOUT_EN
    check("idle_receiving", {31'd0, receiving}, 32'd0);
    check("idle_drop", {24'd0, dropCount}, 32'd1);
`else
    check("idle_receiving", {31'd0, receiving}, 32'd1);
    check("idle_drop", {24'd0, dropCount}, 32'd0);
`endif

    repeat (4) @(negedge clock);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
